spi_cfg_master: RTL

- Host-side SPI master that serialises register-write requests into 16-bit frames for the on-chip SPI register peripheral (output-enable, PWM-enable and duty-cycle registers).
- Accepts (addr, data) writes on a valid/ready interface.
- Generates mode-0 sclk/ncs/copi with programmable timing.
- Reports completion or abort of each frame.
- Sequences all configuration traffic so firmware or test logic never bit-bangs the pins.

---
 rtl/spi_cfg_master_if.sv | 25 ++
 rtl/spi_cfg_master.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/spi_cfg_master_if.sv
// Request, status and SPI pin bundle for spi_cfg_master; "master" is the view of the SPI
// master block itself, "slave" the view of whoever issues writes and watches the pins.
interface spi_cfg_master_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       abort;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       busy;
    logic       done;
    logic       aborted;

    modport master (
        input  req_valid, req_addr, req_data, abort,
        output req_ready, sclk, copi, ncs, busy, done, aborted
    );

    modport slave (
        output req_valid, req_addr, req_data, abort,
        input  req_ready, sclk, copi, ncs, busy, done, aborted
    );
endinterface

// File: rtl/spi_cfg_master.sv
// Mode-0 SPI master sending 16-bit register-write frames; period 1+CS_SETUP+32*CLK_DIV+CS_HOLD+CS_GAP.
// Backpressure via req_ready; SPI_CFG_FIFO_EN selects a 4-deep request FIFO instead of one holding register.
module spi_cfg_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_cfg_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic        phase_q, phase_d;
    logic [15:0] sh_q, sh_d;
    logic        done_q, done_d;
    logic        abt_q, abt_d;

    logic        pending;
    logic        push;
    logic        pop;
    logic [14:0] head;

    assign push = bus.req_valid & bus.req_ready;
    assign pop  = (state_q == IDLE) & pending;

`ifdef SPI_CFG_FIFO_EN
    logic [14:0] mem_q [4];
    logic [1:0]  wp_q, rp_q;
    logic [2:0]  occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wp_q] <= {bus.req_data, bus.req_addr};
                wp_q        <= wp_q + 2'd1;
            end
            if (pop) rp_q <= rp_q + 2'd1;
            occ_q <= occ_q + {2'b00, push} - {2'b00, pop};
        end
    end

    assign pending       = (occ_q != 3'd0);
    assign head          = mem_q[rp_q];
    assign bus.req_ready = (occ_q != 3'd4);
`else
    logic        hold_vld_q;
    logic [14:0] hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else if (push) begin
            hold_vld_q <= 1'b1;
            hold_q     <= {bus.req_data, bus.req_addr};
        end else if (pop) begin
            hold_vld_q <= 1'b0;
        end
    end

    assign pending       = hold_vld_q;
    assign head          = hold_q;
    assign bus.req_ready = (state_q == IDLE) & ~hold_vld_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            sh_q    <= '0;
            done_q  <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
            abt_q   <= abt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        bit_d   = bit_q;
        phase_d = phase_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        abt_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pending) begin
                    sh_d    = {head, 1'b1};
                    bit_d   = '0;
                    phase_d = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: if (cnt_q == 8'(CS_SETUP - 1)) begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: if (cnt_q == 8'(CLK_DIV - 1)) begin
                cnt_d = '0;
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (bit_q == 5'd15) begin
                    phase_d = 1'b0;
                    state_d = HOLD;
                end else begin
                    // next bit is presented on the same edge that drops sclk
                    phase_d = 1'b0;
                    bit_d   = bit_q + 5'd1;
                    sh_d    = {1'b0, sh_q[15:1]};
                end
            end
            HOLD: if (cnt_q == 8'(CS_HOLD - 1)) begin
                cnt_d   = '0;
                state_d = GAP;
                done_d  = 1'b1;
            end
            GAP: if (cnt_q == 8'(CS_GAP - 1)) begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // once in HOLD every bit is already out, so only SETUP/SHIFT can be cut short
        if (bus.abort && (state_q == SETUP || state_q == SHIFT)) begin
            state_d = GAP;
            cnt_d   = '0;
            phase_d = 1'b0;
            sh_d    = '0;
            abt_d   = 1'b1;
        end
    end

    assign bus.ncs     = !(state_q inside {SETUP, SHIFT, HOLD});
    assign bus.sclk    = (state_q == SHIFT) & phase_q;
    assign bus.copi    = (state_q == SETUP || state_q == SHIFT) & sh_q[0];
    assign bus.done    = done_q;
    assign bus.aborted = abt_q;
    assign bus.busy    = (state_q != IDLE) | pending;
endmodule
